// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator: walks both operands MSB-first, DIGIT bits per cycle, stopping at the first differing slice.
// Optional two's-complement mode is enabled by defining CMP_SIGNED_EN, which adds the sgn input.
module serial_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef CMP_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  xs;
    logic [WIDTH-1:0]  ys;
    logic [CW-1:0]     cnt;
    logic [DIGIT-1:0]  x_top;
    logic [DIGIT-1:0]  y_top;
    logic [WIDTH-1:0]  cap_mask;

    assign x_top = xs[WIDTH-1 -: DIGIT];
    assign y_top = ys[WIDTH-1 -: DIGIT];

    // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
`ifdef CMP_SIGNED_EN
    assign cap_mask = sgn ? MSB_MASK : '0;
`else
    assign cap_mask = '0;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            cnt   <= '0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs    <= x ^ cap_mask;
                        ys    <= y ^ cap_mask;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (x_top != y_top) begin
                        lt    <= (x_top < y_top);
                        gt    <= (x_top > y_top);
                        state <= DONE;
                    end else if (cnt == LAST) begin
                        eq    <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        xs  <= xs << DIGIT;
                        ys  <= ys << DIGIT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (WIDTH=8, DIGIT=2): driver issues operand pairs, a negedge monitor
// pops expected flags/latency from a queue when out_valid rises and checks hold, idle and reset behaviour.
module tb_serial_comparator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       eq;
    logic       lt;
    logic       gt;
    logic       busy;
`ifdef CMP_SIGNED_EN
    logic       sgn;
`endif

    serial_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
`ifdef CMP_SIGNED_EN
        .sgn       (sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .lt        (lt),
        .gt        (gt),
        .busy      (busy)
    );

    typedef struct packed {
        logic [2:0]  flags;   // {eq, lt, gt}
        logic [31:0] lat;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  cur;
    int    n_vec = 0;
    int    n_bad = 0;
    time   last_acc = 0;
    logic  ov_prev = 1'b0;
    logic  hs_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at t=%0t", nm, act, req, $time);
        end
    endtask

    // Presents one operand pair; returns 1 ns after the accepting edge.
    task automatic issue(input logic [7:0] tx, input logic [7:0] ty, input logic [2:0] flags,
                         input int lat, input bit push);
        int w;
        exp_t e;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        if (push) begin
            e.flags = flags;
            e.lat   = 32'(lat);
            exp_q.push_back(e);
        end
        in_valid = 1'b1;
        x = tx;
        y = ty;
        @(posedge clk);
        last_acc = $time;
        #1;
        in_valid = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
    endtask

    // Monitor: latency measured from accepting edge to out_valid rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("idle_after_hs_ready", 32'(in_ready), 32'd1);
                chk("idle_after_hs_valid", 32'(out_valid), 32'd0);
            end
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("latency", 32'(($time - last_acc - 4) / 10), cur.lat);
                end
            end
            if (out_valid) begin
                chk("flags", 32'({eq, lt, gt}), 32'(cur.flags));
                chk("in_ready_done", 32'(in_ready), 32'd0);
            end else begin
                chk("flags_idle_zero", 32'({eq, lt, gt}), 32'd0);
            end
            if (busy) chk("in_ready_busy", 32'(in_ready), 32'd0);
            ov_prev = out_valid;
            hs_prev = out_valid && out_ready;
        end
    end

    localparam int NV = 10;
    logic [7:0] vx   [NV] = '{8'hA5, 8'h80, 8'hA4, 8'h3C, 8'h12, 8'h20, 8'hFF, 8'h0B, 8'h06, 8'h00};
    logic [7:0] vy   [NV] = '{8'hA5, 8'h7F, 8'hA5, 8'h0C, 8'h13, 8'h30, 8'h00, 8'h09, 8'h0E, 8'h00};
    logic [2:0] vf   [NV] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001, 3'b010, 3'b100};
    int         vlat [NV] = '{4, 1, 4, 2, 4, 2, 1, 4, 3, 4};

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = 8'h00;
        y         = 8'h00;
`ifdef CMP_SIGNED_EN
        sgn       = 1'b0;
`endif
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_outputs", 32'({out_valid, eq, lt, gt, busy}), 32'd0);
        #6;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) issue(vx[i], vy[i], vf[i], vlat[i], 1'b1);

        // Result held while consumer stalls for 3 cycles.
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        out_ready = 1'b0;
        issue(8'hC0, 8'h40, 3'b001, 1, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("stall_valid_seen", 32'(out_valid), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;

        // Reset in the second BUSY cycle discards the comparison.
        issue(8'h12, 8'h12, 3'b100, 4, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_outputs", 32'({out_valid, eq, lt, gt, busy}), 32'd0);
        #5;
        rst_n = 1'b1;
        issue(8'h00, 8'h01, 3'b010, 4, 1'b1);

        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
